// File: rtl/exception_pkg.sv
// rtl/exception_pkg.sv - shared ExcCode constants and types for the exception unit
package exception_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_INT,
        EV_EXC,
        EV_ERET
    } event_t;

    typedef enum logic {
        S_IDLE,
        S_REDIRECT
    } exu_state_t;

endpackage

// File: rtl/exception_priority.sv
// rtl/exception_priority.sv - picks the commit event: interrupt, exception, ERET, none
module exception_priority
    import exception_pkg::*;
(
    input  logic   accept,
    input  logic   int_pending,
    input  logic   exc_valid,
    input  logic   is_eret,
    output event_t ev
);

    // Interrupts beat synchronous exceptions, which beat ERET; nothing without a handshake
    always_comb begin
        ev = EV_NONE;
        if (accept) begin
            if (int_pending) begin
                ev = EV_INT;
            end else if (exc_valid) begin
                ev = EV_EXC;
            end else if (is_eret) begin
                ev = EV_ERET;
            end
        end
    end

endmodule

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - commit-stage exception/ERET sequencer driving cp0 and fetch redirect
module exception_unit
    import exception_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [4:0]  INT_CODE   = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_is_branch,
    input  logic        commit_is_eret,
    input  logic        commit_exc_valid,
    input  logic [4:0]  commit_exc_code,
    input  logic        commit_badvaddr_en,
    input  logic [31:0] commit_badvaddr,
    input  logic        commit_probe_fail,
    input  logic [31:0] epc_address,
    input  logic        allow_interrupt,
    input  logic [7:0]  interrupt_flag,
    output logic        exp_en,
    output logic        exp_badvaddr_en,
    output logic [31:0] exp_badvaddr,
    output logic        exp_bd,
    output logic [4:0]  exp_code,
    output logic [31:0] exp_epc,
    output logic        exl_clean,
    output logic        exp_probe_failure,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    exu_state_t  state;
    exu_state_t  state_nxt;
    event_t      ev;
    logic        accept;
    logic        int_pending;
    logic        in_ds;
    logic [31:0] last_branch_pc;
    logic [4:0]  last_code;
    logic        last_bd;
    logic [4:0]  trap_code;

    // Held low while reset is asserted so every output reads 0 during reset
    assign commit_ready   = rst & (state == S_IDLE);
    assign accept         = commit_valid & commit_ready;
    assign redirect_valid = (state == S_REDIRECT);
    assign trap_code      = (ev == EV_INT) ? INT_CODE : commit_exc_code;

    exception_priority u_priority (
        .accept      (accept),
        .int_pending (int_pending),
        .exc_valid   (commit_exc_valid),
        .is_eret     (commit_is_eret),
        .ev          (ev)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave IDLE on any event; stay in REDIRECT until fetch takes the new PC
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ev != EV_NONE) begin
                    state_nxt = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Interrupt request sampled one cycle ahead of the commit that takes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_pending <= 1'b0;
        end else begin
            int_pending <= allow_interrupt & (|interrupt_flag);
        end
    end

    // cp0 write port, redirect target and delay-slot tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_en            <= 1'b0;
            flush             <= 1'b0;
            exp_badvaddr_en   <= 1'b0;
            exp_badvaddr      <= 32'd0;
            exp_bd            <= 1'b0;
            exp_code          <= 5'd0;
            exp_epc           <= 32'd0;
            exl_clean         <= 1'b0;
            exp_probe_failure <= 1'b0;
            redirect_pc       <= 32'd0;
            in_ds             <= 1'b0;
            last_branch_pc    <= 32'd0;
            last_code         <= 5'd0;
            last_bd           <= 1'b0;
        end else begin
            exp_en <= (ev != EV_NONE);
            flush  <= (ev != EV_NONE);
            case (ev)
                EV_INT, EV_EXC: begin
                    exl_clean         <= 1'b0;
                    exp_bd            <= in_ds;
                    exp_epc           <= in_ds ? last_branch_pc : commit_pc;
                    exp_code          <= trap_code;
                    exp_badvaddr_en   <= (ev == EV_EXC) & commit_badvaddr_en;
                    exp_badvaddr      <= commit_badvaddr;
                    exp_probe_failure <= commit_probe_fail;
                    last_code         <= trap_code;
                    last_bd           <= in_ds;
                    redirect_pc       <= EXC_VECTOR;
                    in_ds             <= 1'b0;
                end
                EV_ERET: begin
                    // Cause is rewritten with its saved value so ERET leaves it unchanged
                    exl_clean         <= 1'b1;
                    exp_epc           <= epc_address;
                    exp_code          <= last_code;
                    exp_bd            <= last_bd;
                    exp_badvaddr_en   <= 1'b0;
                    redirect_pc       <= epc_address;
                    in_ds             <= 1'b0;
                end
                default: begin
                    if (accept) begin
                        in_ds <= commit_is_branch;
                        if (commit_is_branch) begin
                            last_branch_pc <= commit_pc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - scoreboard bench for exception_unit
module tb_exception_unit;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    logic        commit_is_branch;
    logic        commit_is_eret;
    logic        commit_exc_valid;
    logic [4:0]  commit_exc_code;
    logic        commit_badvaddr_en;
    logic [31:0] commit_badvaddr;
    logic        commit_probe_fail;
    logic [31:0] epc_address;
    logic        allow_interrupt;
    logic [7:0]  interrupt_flag;
    logic        exp_en;
    logic        exp_badvaddr_en;
    logic [31:0] exp_badvaddr;
    logic        exp_bd;
    logic [4:0]  exp_code;
    logic [31:0] exp_epc;
    logic        exl_clean;
    logic        exp_probe_failure;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        exl;
        logic        bven;
        logic [31:0] bva;
        logic        probe;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int exp_count = 0;

    logic        m_in_ds;
    logic [31:0] m_last_pc;
    logic [4:0]  m_last_code;
    logic        m_last_bd;
    logic        m_probe;

    exception_unit dut (
        .clk                (clk),
        .rst                (rst),
        .commit_valid       (commit_valid),
        .commit_ready       (commit_ready),
        .commit_pc          (commit_pc),
        .commit_is_branch   (commit_is_branch),
        .commit_is_eret     (commit_is_eret),
        .commit_exc_valid   (commit_exc_valid),
        .commit_exc_code    (commit_exc_code),
        .commit_badvaddr_en (commit_badvaddr_en),
        .commit_badvaddr    (commit_badvaddr),
        .commit_probe_fail  (commit_probe_fail),
        .epc_address        (epc_address),
        .allow_interrupt    (allow_interrupt),
        .interrupt_flag     (interrupt_flag),
        .exp_en             (exp_en),
        .exp_badvaddr_en    (exp_badvaddr_en),
        .exp_badvaddr       (exp_badvaddr),
        .exp_bd             (exp_bd),
        .exp_code           (exp_code),
        .exp_epc            (exp_epc),
        .exl_clean          (exl_clean),
        .exp_probe_failure  (exp_probe_failure),
        .flush              (flush),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .redirect_ready     (redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_in_ds     = 1'b0;
        m_last_pc   = 32'd0;
        m_last_code = 5'd0;
        m_last_bd   = 1'b0;
        m_probe     = 1'b0;
    endtask

    task automatic clear_commit();
        commit_valid       = 1'b0;
        commit_pc          = 32'd0;
        commit_is_branch   = 1'b0;
        commit_is_eret     = 1'b0;
        commit_exc_valid   = 1'b0;
        commit_exc_code    = 5'd0;
        commit_badvaddr_en = 1'b0;
        commit_badvaddr    = 32'd0;
        commit_probe_fail  = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic br, input logic eret,
                             input logic exc, input logic [4:0] code, input logic bven,
                             input logic [31:0] bva, input logic probe, input logic exp_int);
        int n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!commit_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!commit_ready) check("commit_ready_timeout", 32'(commit_ready), 32'd1);
        commit_valid       = 1'b1;
        commit_pc          = pc;
        commit_is_branch   = br;
        commit_is_eret     = eret;
        commit_exc_valid   = exc;
        commit_exc_code    = code;
        commit_badvaddr_en = bven;
        commit_badvaddr    = bva;
        commit_probe_fail  = probe;
        if (exp_int || exc) begin
            e.code  = exp_int ? 5'd0 : code;
            e.epc   = m_in_ds ? m_last_pc : pc;
            e.bd    = m_in_ds;
            e.exl   = 1'b0;
            e.bven  = exp_int ? 1'b0 : bven;
            e.bva   = bva;
            e.probe = probe;
            e.rpc   = VEC;
            m_last_code = e.code;
            m_last_bd   = e.bd;
            m_probe     = probe;
            m_in_ds     = 1'b0;
            sb.push_back(e);
        end else if (eret) begin
            e.code  = m_last_code;
            e.epc   = epc_address;
            e.bd    = m_last_bd;
            e.exl   = 1'b1;
            e.bven  = 1'b0;
            e.bva   = 32'd0;
            e.probe = m_probe;
            e.rpc   = epc_address;
            m_in_ds = 1'b0;
            sb.push_back(e);
        end else begin
            m_in_ds = br;
            if (br) m_last_pc = pc;
        end
        @(posedge clk);
        #1;
        clear_commit();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!commit_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!commit_ready) check("idle_timeout", 32'(commit_ready), 32'd1);
    endtask

    // Scoreboard: every cp0 write strobe must match the oldest expected event
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && exp_en === 1'b1) begin
            exp_count++;
            if (sb.size() == 0) begin
                check("spurious_exp_en", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("exp_code", 32'(exp_code), 32'(e.code));
                check("exp_epc", exp_epc, e.epc);
                check("exp_bd", 32'(exp_bd), 32'(e.bd));
                check("exl_clean", 32'(exl_clean), 32'(e.exl));
                check("exp_badvaddr_en", 32'(exp_badvaddr_en), 32'(e.bven));
                if (e.bven) check("exp_badvaddr", exp_badvaddr, e.bva);
                check("exp_probe_failure", 32'(exp_probe_failure), 32'(e.probe));
                check("flush_with_exp", 32'(flush), 32'd1);
                check("redirect_valid_with_exp", 32'(redirect_valid), 32'd1);
                check("redirect_pc", redirect_pc, e.rpc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst             = 1'b0;
        clear_commit();
        epc_address     = 32'd0;
        allow_interrupt = 1'b0;
        interrupt_flag  = 8'd0;
        redirect_ready  = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_commit_ready", 32'(commit_ready), 32'd0);
        check("rst_exp_en", 32'(exp_en), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_exp_epc", exp_epc, 32'd0);
        rst = 1'b1;
        #1;
        check("post_rst_commit_ready", 32'(commit_ready), 32'd1);

        // Sys exception, then back to IDLE one cycle after the strobe
        do_commit(32'h80001000, 0, 0, 1, 5'd8, 0, 32'd0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("idle_after_redirect", 32'(commit_ready), 32'd1);
        check("redirect_dropped", 32'(redirect_valid), 32'd0);
        check("exp_en_one_cycle", 32'(exp_en), 32'd0);
        check("flush_one_cycle", 32'(flush), 32'd0);

        // ERET restores EPC and keeps Cause
        epc_address = 32'h80004000;
        do_commit(32'h80001100, 0, 1, 0, 5'd0, 0, 32'd0, 0, 0);
        wait_idle();

        // Branch then excepting delay slot
        do_commit(32'h80002000, 1, 0, 0, 5'd0, 0, 32'd0, 0, 0);
        do_commit(32'h80002004, 0, 0, 1, 5'd4, 1, 32'h13, 0, 0);
        wait_idle();

        // Excepting branch must not mark the next instruction as a delay slot
        do_commit(32'h80002100, 1, 0, 1, 5'd10, 0, 32'd0, 0, 0);
        wait_idle();
        do_commit(32'h80002104, 0, 0, 1, 5'd12, 0, 32'd0, 0, 0);
        wait_idle();

        // Pending interrupt beats the instruction's own exception
        allow_interrupt = 1'b1;
        interrupt_flag  = 8'h04;
        repeat (2) @(posedge clk);
        do_commit(32'h80003000, 0, 0, 1, 5'd8, 1, 32'h55, 1, 1);
        allow_interrupt = 1'b0;
        interrupt_flag  = 8'h00;
        wait_idle();

        // Fetch stalls the redirect for five cycles while commit keeps offering
        redirect_ready = 1'b0;
        base = exp_count;
        do_commit(32'h80005000, 0, 0, 1, 5'd8, 0, 32'd0, 0, 0);
        commit_valid     = 1'b1;
        commit_pc        = 32'h80005004;
        commit_exc_valid = 1'b1;
        commit_exc_code  = 5'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_commit_ready", 32'(commit_ready), 32'd0);
            check("stall_redirect_valid", 32'(redirect_valid), 32'd1);
            check("stall_redirect_pc", redirect_pc, VEC);
        end
        clear_commit();
        redirect_ready = 1'b1;
        @(negedge clk);
        check("stall_released", 32'(redirect_valid), 32'd0);
        check("stall_idle", 32'(commit_ready), 32'd1);
        check("stall_single_exp", 32'(exp_count - base), 32'd1);

        // Reset in the middle of a redirect
        redirect_ready = 1'b0;
        do_commit(32'h80006000, 0, 0, 1, 5'd8, 0, 32'd0, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("async_rst_flush", 32'(flush), 32'd0);
        check("async_rst_exp_en", 32'(exp_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        redirect_ready = 1'b1;
        #1;
        check("rst_release_commit_ready", 32'(commit_ready), 32'd1);
        base = exp_count;
        repeat (3) @(negedge clk);
        check("no_exp_after_rst", 32'(exp_count - base), 32'd0);

        // Reset clears a pending delay-slot mark
        do_commit(32'h80007000, 1, 0, 0, 5'd0, 0, 32'd0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        do_commit(32'h80007004, 0, 0, 1, 5'd8, 0, 32'd0, 0, 0);
        wait_idle();

        // ready pulses with no redirect pending are ignored
        redirect_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready_ignored", 32'(redirect_valid), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Commit-stage exception and ERET sequencer that drives the cp0 exception write port (exp_en, exp_code, exp_epc, exp_bd, exl_clean, badvaddr, probe failure).
- Uses cp0's epc_address, allow_interrupt and interrupt_flag to take precise interrupts and to return from ERET.
- Tracks branch delay slots, flushes the pipeline, and holds a PC redirect to fetch until fetch accepts it.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry PC
INT_CODE, 5'd0, ExcCode written to cp0 for an interrupt

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
commit_valid  in  1  an instruction is offered at commit
commit_ready  out  1  commit accepted this cycle (commit_valid & commit_ready)
commit_pc  in  32  PC of the offered instruction
commit_is_branch  in  1  offered instruction owns a delay slot
commit_is_eret  in  1  offered instruction is ERET
commit_exc_valid  in  1  offered instruction raised a synchronous exception
commit_exc_code  in  5  ExcCode of that exception
commit_badvaddr_en  in  1  exception carries a BadVAddr
commit_badvaddr  in  32  faulting address
commit_probe_fail  in  1  TLB probe failure flag
epc_address  in  32  cp0 EPC
allow_interrupt  in  1  cp0 Status IE/EXL/ERL permit interrupts
interrupt_flag  in  8  cp0 IM & IP
exp_en  out  1  one-cycle cp0 exception-write strobe
exp_badvaddr_en  out  1  BadVAddr write enable, qualified by exp_en
exp_badvaddr  out  32  BadVAddr value
exp_bd  out  1  Cause.BD value
exp_code  out  5  Cause.ExcCode value
exp_epc  out  32  EPC value
exl_clean  out  1  1 = ERET (clears EXL), 0 = exception (sets EXL)
exp_probe_failure  out  1  Index.P value
flush  out  1  one-cycle pipeline flush pulse
redirect_valid  out  1  redirect PC pending
redirect_pc  out  32  target PC
redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset (async, rst=0):
  - State IDLE.
  - All outputs 0, except commit_ready=1 once rst is released in IDLE.
  - Internal registers cleared: int_pending, in_ds, last_branch_pc, last_code, last_bd.
- int_pending is registered every cycle as allow_interrupt & |interrupt_flag, so interrupt sampling has one cycle of latency.
- commit_ready = (state==IDLE).
- On acceptance, the event is chosen by priority:
  - interrupt: int_pending
  - exception: commit_exc_valid
  - ERET: commit_is_eret
  - none
- Delay slot:
  - in_ds is set when a branch with no event is accepted, and last_branch_pc <= commit_pc.
  - Any other accepted instruction clears in_ds.
  - An accepted event also clears in_ds.
- Interrupt or exception, registered outputs in the cycle after acceptance:
  - exp_en=1, flush=1 (both one cycle).
  - exl_clean=0.
  - exp_bd=in_ds.
  - exp_epc = in_ds ? last_branch_pc : commit_pc.
  - exp_code = INT_CODE for an interrupt, otherwise commit_exc_code.
  - exp_badvaddr_en = commit_badvaddr_en, and 0 for an interrupt.
  - exp_probe_failure = commit_probe_fail.
  - Latch last_code=exp_code and last_bd=exp_bd.
  - redirect_pc=EXC_VECTOR.
- ERET, registered outputs in the cycle after acceptance:
  - exp_en=1, flush=1, exl_clean=1.
  - exp_epc = epc_address sampled at acceptance, so EPC is preserved.
  - exp_code=last_code and exp_bd=last_bd, so Cause is preserved.
  - exp_badvaddr_en=0; exp_probe_failure holds its previous value.
  - redirect_pc = sampled epc_address.
- FSM:
  - IDLE -> REDIRECT on an accepted event; redirect_valid=1 from the cycle after acceptance.
  - REDIRECT holds redirect_valid and redirect_pc stable until redirect_valid & redirect_ready, then returns to IDLE. redirect_valid deasserts the following cycle.
  - No-event commits stay in IDLE with no side effects except in_ds tracking.
- Boundaries:
  - commit_valid during REDIRECT is ignored (commit_ready=0).
  - redirect_ready while redirect_valid=0 is ignored.
  - Asserting rst mid-REDIRECT drops redirect_valid immediately; no second exp_en is issued.
  - An excepting branch does not set in_ds.

Decomposition:
- Package exception_pkg holds:
  - ExcCode constants: EXC_INT, EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV.
  - typedef enum logic [1:0] {EV_NONE, EV_INT, EV_EXC, EV_ERET} event_t.
  - typedef enum logic {S_IDLE, S_REDIRECT} exu_state_t.
- Sub-module: exception_priority, a combinational event_t selector; everything else stays inline.

Test Plan:
- Sys exception at commit_pc=0x80001000, code 8, redirect_ready=1 -> next cycle:
  - exp_en=1, exp_code=8, exp_epc=0x80001000, exp_bd=0, exl_clean=0.
  - flush=1, redirect_pc=0xBFC00380.
  - Back in IDLE one cycle later.
- Branch at 0x80002000, then delay slot at 0x80002004 with AdEL code 4, badvaddr 0x13 -> exp_bd=1, exp_epc=0x80002000, exp_badvaddr_en=1, exp_badvaddr=0x13.
- allow_interrupt=1, interrupt_flag=0x04 for 2 cycles, then commit of 0x80003000 carrying a Sys exception -> interrupt wins: exp_code=0, exp_epc=0x80003000, exp_badvaddr_en=0.
- ERET with epc_address=0x80004000 after the first test -> exl_clean=1, exp_epc=0x80004000, exp_code=8, redirect_pc=0x80004000.
- redirect_ready held low 5 cycles with commit_valid=1 -> commit_ready=0 and redirect_valid stable for 5 cycles; single exp_en; accepted on the 6th cycle.
- rst=0 asserted mid-REDIRECT -> redirect_valid, flush and exp_en go 0 asynchronously; after release, commit_ready=1 and in_ds=0.
